conv_pool_sequencer: RTL

Frame-level controller for the streaming 3x3 convolution plus 2x2 max-pool datapath. It generates input-RAM read addresses, the input window-buffer shift enable, conv-valid strobes (the pool window-buffer enable) and pool-valid/write strobes with output-RAM write addresses. It replaces ad-hoc per-test control FSMs with one start/done block that processes a whole frame.

---
 rtl/conv_pool_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/conv_pool_sequencer.sv
// conv_pool_sequencer: frame-level read/window/conv/pool/write strobe generator for the conv+pool datapath
module conv_pool_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int N_ROWS      = 108,
    parameter int N_COLS      = 160,
    parameter int KERNEL_SIZE = 3,
    parameter int POOL_SIZE   = 2,
    parameter int RD_LAT      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_en_o,
    output logic                  win_en_o,
    output logic                  conv_valid_o,
    output logic                  pool_valid_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o
);
    localparam int NPIX = N_ROWS * N_COLS;
    localparam int CR   = N_ROWS - KERNEL_SIZE + 1;
    localparam int CC   = N_COLS - KERNEL_SIZE + 1;
    localparam int PR   = CR / POOL_SIZE;
    localparam int PC   = CC / POOL_SIZE;
    localparam int CW   = $clog2(N_COLS) + 1;
    localparam int RW   = $clog2(N_ROWS) + 1;
    localparam int PW   = $clog2(POOL_SIZE) + 1;
    localparam int DW   = $clog2(RD_LAT + 2) + 1;
    localparam int VL   = RD_LAT;
    localparam int CL   = RD_LAT + 1;
    localparam int PL   = RD_LAT + 2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [CW-1:0]         LAST_COL  = CW'(N_COLS - 1);
    localparam logic [CW-1:0]         K1_C      = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0]         COL_LIM   = CW'(KERNEL_SIZE - 1 + PC * POOL_SIZE);
    localparam logic [RW-1:0]         K1_R      = RW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0]         ROW_LIM   = RW'(KERNEL_SIZE - 1 + PR * POOL_SIZE);
    localparam logic [PW-1:0]         P1        = PW'(POOL_SIZE - 1);
    localparam logic [DW-1:0]         DR_LAST   = DW'(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wr_q, wr_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [PW-1:0]         pc_q, pc_d;
    logic [PW-1:0]         pr_q, pr_d;
    logic [DW-1:0]         dr_q, dr_d;
    logic [VL-1:0]         v_q, v_d;
    logic [CL-1:0]         c_q, c_d;
    logic [PL-1:0]         p_q, p_d;
    logic                  go, run, last_col, is_conv, is_pool;

    // Next-state, counter and tag-pipeline logic; tags are generated at the issue cycle and delayed to RAM latency
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        col_d    = col_q;
        row_d    = row_q;
        pc_d     = pc_q;
        pr_d     = pr_q;
        go       = (state_q == IDLE || state_q == DONE) && start_i;
        run      = state_q == RUN;
        last_col = col_q == LAST_COL;
        is_conv  = run && row_q >= K1_R && col_q >= K1_C;
        is_pool  = is_conv && pr_q == P1 && pc_q == P1 && row_q < ROW_LIM && col_q < COL_LIM;
        case (state_q)
            IDLE:    state_d = start_i ? RUN : IDLE;
            RUN:     state_d = addr_q == LAST_ADDR ? DRAIN : RUN;
            DRAIN:   state_d = dr_q == DR_LAST ? DONE : DRAIN;
            default: state_d = start_i ? RUN : IDLE;
        endcase
        if (go) begin
            addr_d = '0;
            col_d  = '0;
            row_d  = '0;
            pc_d   = '0;
            pr_d   = '0;
        end else if (run) begin
            addr_d = addr_q + 1'b1;
            col_d  = last_col ? '0 : col_q + 1'b1;
            row_d  = last_col ? row_q + 1'b1 : row_q;
            if (col_q >= K1_C) pc_d = pc_q == P1 ? '0 : pc_q + 1'b1;
            if (last_col) pc_d = '0;
            if (last_col && row_q >= K1_R) pr_d = pr_q == P1 ? '0 : pr_q + 1'b1;
        end
        dr_d         = state_q == DRAIN ? dr_q + 1'b1 : '0;
        v_d          = VL'({v_q, run});
        c_d          = CL'({c_q, is_conv});
        p_d          = PL'({p_q, is_pool});
        busy_o       = state_q == RUN || state_q == DRAIN;
        done_o       = state_q == DONE;
        rd_en_o      = run;
        rd_addr_o    = run ? addr_q : '0;
        win_en_o     = v_q[VL-1];
        conv_valid_o = c_q[CL-1];
        pool_valid_o = p_q[PL-1];
        wr_en_o      = p_q[PL-1];
        wr_addr_o    = wr_q;
        wr_d         = go ? '0 : (p_q[PL-1] ? wr_q + 1'b1 : wr_q);
    end

    // State, counter and pipeline registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pc_q    <= '0;
            pr_q    <= '0;
            dr_q    <= '0;
            v_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pc_q    <= pc_d;
            pr_q    <= pr_d;
            dr_q    <= dr_d;
            v_q     <= v_d;
            c_q     <= c_d;
            p_q     <= p_d;
        end
    end
endmodule
